// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and the register file.
// The write-port selection encoding lives here so the register file can decode it when needed.
package rf_wb_arbiter_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  localparam logic [1:0] SEL_IDLE  = 2'd0;
  localparam logic [1:0] SEL_ALU   = 2'd1;
  localparam logic [1:0] SEL_DRAIN = 2'd2;
  localparam logic [1:0] SEL_FORCE = 2'd3;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// wb_fifo: in-order buffer of pending long-latency writebacks (address + data per entry).
// With RF_WB_HAZARD_EN defined, every slot's address and occupancy are exported for hazard queries.
module wb_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [ADDR_WIDTH-1:0]      push_addr_i,
  input  logic [DATA_WIDTH-1:0]      push_data_i,
  input  logic                       pop_i,
  output logic [ADDR_WIDTH-1:0]      head_addr_o,
  output logic [DATA_WIDTH-1:0]      head_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
`ifdef RF_WB_HAZARD_EN
  ,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr_o,
  output logic [DEPTH-1:0]                 entry_valid_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addrMem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dataMem_q [DEPTH];
  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap naturally at PW bits.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) wrPtr_d = wrPtr_q + PW'(1);
    if (pop_i)  rdPtr_d = rdPtr_q + PW'(1);
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (pop_i && !push_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !rst) begin
      addrMem_q[wrPtr_q] <= push_addr_i;
      dataMem_q[wrPtr_q] <= push_data_i;
    end
  end

  assign head_addr_o = addrMem_q[rdPtr_q];
  assign head_data_o = dataMem_q[rdPtr_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);

`ifdef RF_WB_HAZARD_EN
  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] offset;
    assign offset           = PW'(i) - rdPtr_q;
    assign entry_addr_o[i]  = addrMem_q[i];
    assign entry_valid_o[i] = ({1'b0, offset} < count_q);
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU and buffered long-latency writebacks onto the single RF write port.
// Define RF_WB_HAZARD_EN to add the q_addr*/q_busy* pending-write hazard query ports.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = RF_ADDR_WIDTH,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_waddr,
  input  logic [DATA_WIDTH-1:0] alu_wdata,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef RF_WB_HAZARD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] q_addr1,
  input  logic [ADDR_WIDTH-1:0] q_addr2,
  output logic                  q_busy1,
  output logic                  q_busy2
`endif
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]         StarveMax = SW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr  = ADDR_WIDTH'(ZERO_REG);

  logic                  fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [CW-1:0]         fifoCount;
  logic [ADDR_WIDTH-1:0] headAddr;
  logic [DATA_WIDTH-1:0] headData;
  logic                  forcePop;
  logic [1:0]            sel;

  logic                  rfWen_q, rfWen_d;
  logic [ADDR_WIDTH-1:0] rfWaddr_q, rfWaddr_d;
  logic [DATA_WIDTH-1:0] rfWdata_q, rfWdata_d;
  logic [SW-1:0]         starve_q, starve_d;

`ifdef RF_WB_HAZARD_EN
  logic [LQ_DEPTH-1:0][ADDR_WIDTH-1:0] entryAddr;
  logic [LQ_DEPTH-1:0]                 entryValid;
`endif

  wb_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (LQ_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifoPush),
    .push_addr_i(lsu_waddr),
    .push_data_i(lsu_wdata),
    .pop_i      (fifoPop),
    .head_addr_o(headAddr),
    .head_data_o(headData),
    .count_o    (fifoCount),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
`ifdef RF_WB_HAZARD_EN
    ,
    .entry_addr_o (entryAddr),
    .entry_valid_o(entryValid)
`endif
  );

  // Both readies come from registered state only, never from the valids.
  assign lsu_ready = (fifoCount < CW'(LQ_DEPTH));
  assign forcePop  = (starve_q == StarveMax) && !fifoEmpty;
  assign alu_ready = !forcePop;

  // Writes to $0 are accepted but never reach the buffer.
  assign fifoPush = lsu_valid && !fifoFull && (lsu_waddr != ZeroAddr);

  always_comb begin
    sel = SEL_IDLE;
    if (forcePop)        sel = SEL_FORCE;
    else if (alu_valid)  sel = SEL_ALU;
    else if (!fifoEmpty) sel = SEL_DRAIN;
  end

  assign fifoPop = (sel == SEL_FORCE) || (sel == SEL_DRAIN);

  always_comb begin
    rfWen_d   = 1'b0;
    rfWaddr_d = rfWaddr_q;
    rfWdata_d = rfWdata_q;
    if (sel == SEL_ALU && alu_waddr != ZeroAddr) begin
      rfWen_d   = 1'b1;
      rfWaddr_d = alu_waddr;
      rfWdata_d = alu_wdata;
    end else if (fifoPop) begin
      rfWen_d   = 1'b1;
      rfWaddr_d = headAddr;
      rfWdata_d = headData;
    end
  end

  // Counts consecutive cycles a waiting head was passed over, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (fifoEmpty || fifoPop)     starve_d = '0;
    else if (starve_q != StarveMax) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rfWen_q   <= 1'b0;
      rfWaddr_q <= '0;
      rfWdata_q <= '0;
      starve_q  <= '0;
    end else begin
      rfWen_q   <= rfWen_d;
      rfWaddr_q <= rfWaddr_d;
      rfWdata_q <= rfWdata_d;
      starve_q  <= starve_d;
    end
  end

  assign rf_wen   = rfWen_q;
  assign rf_waddr = rfWaddr_q;
  assign rf_wdata = rfWdata_q;

`ifdef RF_WB_HAZARD_EN
  // A register is busy while buffered or while its write is on the port this cycle.
  function automatic logic pendingWrite(
    input logic [ADDR_WIDTH-1:0]               qAddr,
    input logic [LQ_DEPTH-1:0]                 valid,
    input logic [LQ_DEPTH-1:0][ADDR_WIDTH-1:0] addrs,
    input logic                                wen,
    input logic [ADDR_WIDTH-1:0]               waddr
  );
    logic hit;
    hit = wen && (waddr == qAddr);
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (valid[i] && addrs[i] == qAddr) hit = 1'b1;
    end
    return hit && (qAddr != ZeroAddr);
  endfunction

  assign q_busy1 = pendingWrite(q_addr1, entryValid, entryAddr, rfWen_q, rfWaddr_q);
  assign q_busy2 = pendingWrite(q_addr2, entryValid, entryAddr, rfWen_q, rfWaddr_q);
`endif

endmodule
